// File: rtl/alu_reservation_station.sv
// ALU reservation station: buffers dispatched ALU ops until both operands are
// valid, snoops the CDB for pending producer tags, and presents one ready op at
// a time to the ALU. The entry is freed when the ALU reports completion.
module alu_reservation_station #(
  parameter int DEPTH    = 4,
  parameter int BASE_TAG = 1,
  parameter int TAG_W    = 4
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             flush,
  input  logic             disp_valid,
  output logic             disp_ready,
  input  logic [3:0]       disp_alu_fun,
  input  logic [31:0]      disp_V1,
  input  logic             disp_V1_valid,
  input  logic [TAG_W-1:0] disp_Q1,
  input  logic [31:0]      disp_V2,
  input  logic             disp_V2_valid,
  input  logic [TAG_W-1:0] disp_Q2,
  output logic [TAG_W-1:0] disp_tag,
  input  logic [31:0]      CDB_val,
  input  logic [TAG_W-1:0] CDB_tag,
  output logic             iss_valid,
  output logic [31:0]      iss_V1,
  output logic [31:0]      iss_V2,
  output logic             iss_V1_valid,
  output logic             iss_V2_valid,
  output logic [3:0]       iss_alu_fun,
  output logic [TAG_W-1:0] iss_rd_tag,
  input  logic             alu_done
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [TAG_W-1:0] INVALID_TAG = '0;

  // per-entry state
  logic [DEPTH-1:0] busy_reg;
  logic [DEPTH-1:0] issued_reg;
  logic [DEPTH-1:0] v1v_reg;
  logic [DEPTH-1:0] v2v_reg;
  logic [3:0]       fun_reg [DEPTH];
  logic [31:0]      v1_reg  [DEPTH];
  logic [31:0]      v2_reg  [DEPTH];
  logic [TAG_W-1:0] q1_reg  [DEPTH];
  logic [TAG_W-1:0] q2_reg  [DEPTH];

  logic [DEPTH-1:0] ready_vec;
  logic [IDX_W-1:0] free_idx;
  logic [IDX_W-1:0] ready_idx;
  logic [IDX_W-1:0] iss_idx;
  logic             free_found;
  logic             ready_found;
  logic             accept;
  logic             done;
  logic             sel_en;
  logic             cdb_hit;

  // priority encoders: lowest free entry, lowest ready-not-issued entry, issued entry
  always_comb begin
    free_found  = 1'b0;
    free_idx    = '0;
    ready_found = 1'b0;
    ready_idx   = '0;
    iss_idx     = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!busy_reg[i]) begin
        free_found = 1'b1;
        free_idx   = i[IDX_W-1:0];
      end
      if (ready_vec[i]) begin
        ready_found = 1'b1;
        ready_idx   = i[IDX_W-1:0];
      end
      if (issued_reg[i]) begin
        iss_idx = i[IDX_W-1:0];
      end
    end
  end

  assign ready_vec  = busy_reg & v1v_reg & v2v_reg & ~issued_reg;
  assign disp_ready = free_found;
  assign disp_tag   = free_found ? (TAG_W'(BASE_TAG) + TAG_W'(free_idx)) : INVALID_TAG;
  assign accept     = disp_valid && free_found && !flush;
  assign iss_valid  = |issued_reg;
  assign done       = alu_done && iss_valid;
  // a new op may be selected on the same edge the current one completes
  assign sel_en     = ready_found && (!iss_valid || alu_done);
  assign cdb_hit    = (CDB_tag != INVALID_TAG);

  // issue bus is a mux of the (registered) issued entry; zeros when idle
  assign iss_V1       = iss_valid ? v1_reg[iss_idx]  : 32'd0;
  assign iss_V2       = iss_valid ? v2_reg[iss_idx]  : 32'd0;
  assign iss_alu_fun  = iss_valid ? fun_reg[iss_idx] : 4'd0;
  assign iss_rd_tag   = iss_valid ? (TAG_W'(BASE_TAG) + TAG_W'(iss_idx)) : INVALID_TAG;
  assign iss_V1_valid = iss_valid;
  assign iss_V2_valid = iss_valid;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      // entry lifecycle: allocate (with CDB forwarding), wake up, issue, free
      always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
          busy_reg[gi]   <= 1'b0;
          issued_reg[gi] <= 1'b0;
          v1v_reg[gi]    <= 1'b0;
          v2v_reg[gi]    <= 1'b0;
          fun_reg[gi]    <= '0;
          v1_reg[gi]     <= '0;
          v2_reg[gi]     <= '0;
          q1_reg[gi]     <= '0;
          q2_reg[gi]     <= '0;
        end else if (flush) begin
          busy_reg[gi]   <= 1'b0;
          issued_reg[gi] <= 1'b0;
        end else if (accept && (free_idx == IDX_W'(gi))) begin
          busy_reg[gi] <= 1'b1;
          fun_reg[gi]  <= disp_alu_fun;
          q1_reg[gi]   <= disp_Q1;
          q2_reg[gi]   <= disp_Q2;
          if (disp_V1_valid) begin
            v1_reg[gi]  <= disp_V1;
            v1v_reg[gi] <= 1'b1;
          end else begin
            v1_reg[gi]  <= CDB_val;
            v1v_reg[gi] <= cdb_hit && (disp_Q1 == CDB_tag);
          end
          if (disp_V2_valid) begin
            v2_reg[gi]  <= disp_V2;
            v2v_reg[gi] <= 1'b1;
          end else begin
            v2_reg[gi]  <= CDB_val;
            v2v_reg[gi] <= cdb_hit && (disp_Q2 == CDB_tag);
          end
        end else if (busy_reg[gi]) begin
          if (!v1v_reg[gi] && cdb_hit && (q1_reg[gi] == CDB_tag)) begin
            v1_reg[gi]  <= CDB_val;
            v1v_reg[gi] <= 1'b1;
          end
          if (!v2v_reg[gi] && cdb_hit && (q2_reg[gi] == CDB_tag)) begin
            v2_reg[gi]  <= CDB_val;
            v2v_reg[gi] <= 1'b1;
          end
          if (done && issued_reg[gi]) begin
            busy_reg[gi]   <= 1'b0;
            issued_reg[gi] <= 1'b0;
          end else if (sel_en && (ready_idx == IDX_W'(gi))) begin
            issued_reg[gi] <= 1'b1;
          end
        end
      end
    end
  endgenerate

  // an operand that is neither valid nor waiting on a real producer is a dispatch bug
  assert property (@(posedge CLK) disable iff (!RST_N)
    accept |-> ((disp_V1_valid || (disp_Q1 != INVALID_TAG)) &&
                (disp_V2_valid || (disp_Q2 != INVALID_TAG))));

endmodule

// File: tb/tb_alu_reservation_station.sv
// Directed bench for alu_reservation_station: dispatch, wakeup, forwarding,
// full handling, issue ordering, flush and asynchronous reset.
module tb_alu_reservation_station;

  logic        CLK;
  logic        RST_N;
  logic        flush;
  logic        disp_valid;
  logic        disp_ready;
  logic [3:0]  disp_alu_fun;
  logic [31:0] disp_V1;
  logic        disp_V1_valid;
  logic [3:0]  disp_Q1;
  logic [31:0] disp_V2;
  logic        disp_V2_valid;
  logic [3:0]  disp_Q2;
  logic [3:0]  disp_tag;
  logic [31:0] CDB_val;
  logic [3:0]  CDB_tag;
  logic        iss_valid;
  logic [31:0] iss_V1;
  logic [31:0] iss_V2;
  logic        iss_V1_valid;
  logic        iss_V2_valid;
  logic [3:0]  iss_alu_fun;
  logic [3:0]  iss_rd_tag;
  logic        alu_done;

  int checks = 0;
  int errors = 0;

  alu_reservation_station dut (
    .CLK(CLK), .RST_N(RST_N), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_alu_fun(disp_alu_fun),
    .disp_V1(disp_V1), .disp_V1_valid(disp_V1_valid), .disp_Q1(disp_Q1),
    .disp_V2(disp_V2), .disp_V2_valid(disp_V2_valid), .disp_Q2(disp_Q2),
    .disp_tag(disp_tag), .CDB_val(CDB_val), .CDB_tag(CDB_tag),
    .iss_valid(iss_valid), .iss_V1(iss_V1), .iss_V2(iss_V2),
    .iss_V1_valid(iss_V1_valid), .iss_V2_valid(iss_V2_valid),
    .iss_alu_fun(iss_alu_fun), .iss_rd_tag(iss_rd_tag), .alu_done(alu_done)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    $display("check %-14s observed=%0h expected=%0h", tag, obs, exp);
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic disp(input logic [3:0] fun, input logic [31:0] v1, input logic v1v,
                      input logic [3:0] q1, input logic [31:0] v2, input logic v2v,
                      input logic [3:0] q2);
    disp_valid    = 1'b1;
    disp_alu_fun  = fun;
    disp_V1       = v1;
    disp_V1_valid = v1v;
    disp_Q1       = q1;
    disp_V2       = v2;
    disp_V2_valid = v2v;
    disp_Q2       = q2;
  endtask

  task automatic idle();
    disp_valid    = 1'b0;
    disp_alu_fun  = 4'd0;
    disp_V1       = 32'd0;
    disp_V1_valid = 1'b1;
    disp_Q1       = 4'd0;
    disp_V2       = 32'd0;
    disp_V2_valid = 1'b1;
    disp_Q2       = 4'd0;
  endtask

  initial begin
    RST_N    = 1'b0;
    flush    = 1'b0;
    alu_done = 1'b0;
    CDB_val  = 32'd0;
    CDB_tag  = 4'd0;
    idle();
    tick();
    tick();
    chk("rst_iss_valid", iss_valid, 0);
    chk("rst_disp_rdy", disp_ready, 1);
    chk("rst_disp_tag", disp_tag, 1);
    chk("rst_rd_tag", iss_rd_tag, 0);
    chk("rst_iss_v1", iss_V1, 0);
    RST_N = 1'b1;
    tick();

    // 1: add with both operands ready
    disp(4'd0, 32'd5, 1'b1, 4'd0, 32'd7, 1'b1, 4'd0);
    chk("t1_disp_tag", disp_tag, 1);
    tick();
    idle();
    chk("t1_gap_valid", iss_valid, 0);
    chk("t1_next_tag", disp_tag, 2);
    tick();
    chk("t1_iss_valid", iss_valid, 1);
    chk("t1_iss_v1", iss_V1, 5);
    chk("t1_iss_v2", iss_V2, 7);
    chk("t1_iss_fun", iss_alu_fun, 0);
    chk("t1_rd_tag", iss_rd_tag, 1);
    chk("t1_v1_valid", iss_V1_valid, 1);
    alu_done = 1'b1;
    tick();
    alu_done = 1'b0;
    chk("t1_freed_valid", iss_valid, 0);
    chk("t1_freed_rdy", disp_ready, 1);
    chk("t1_freed_tag", disp_tag, 1);

    // 2: sub waiting on tag 3, CDB wakeup; INVALID broadcast ignored
    disp(4'd8, 32'd0, 1'b0, 4'd3, 32'd2, 1'b1, 4'd0);
    tick();
    idle();
    CDB_tag = 4'd0;
    CDB_val = 32'd10;
    tick();
    chk("t2_noissue_a", iss_valid, 0);
    tick();
    chk("t2_noissue_b", iss_valid, 0);
    CDB_tag = 4'd3;
    tick();
    CDB_tag = 4'd0;
    CDB_val = 32'd0;
    chk("t2_wake_lat", iss_valid, 0);
    tick();
    chk("t2_iss_valid", iss_valid, 1);
    chk("t2_iss_v1", iss_V1, 10);
    chk("t2_iss_v2", iss_V2, 2);
    chk("t2_iss_fun", iss_alu_fun, 8);
    alu_done = 1'b1;
    tick();
    alu_done = 1'b0;

    // 3: dispatch-time forwarding from the CDB
    disp(4'd2, 32'd0, 1'b0, 4'd2, 32'd1, 1'b1, 4'd0);
    CDB_tag = 4'd2;
    CDB_val = 32'hDEAD;
    tick();
    idle();
    CDB_tag = 4'd0;
    CDB_val = 32'd0;
    tick();
    chk("t3_iss_valid", iss_valid, 1);
    chk("t3_iss_v1", iss_V1, 32'hDEAD);
    chk("t3_rd_tag", iss_rd_tag, 1);
    alu_done = 1'b1;
    tick();
    alu_done = 1'b0;

    // 4: fill all entries, dispatch while full is dropped
    for (int i = 0; i < 4; i++) begin
      disp(4'd0, 32'd100 + 32'(i), 1'b1, 4'd0, 32'd0, 1'b1, 4'd0);
      tick();
    end
    chk("t4_full_rdy", disp_ready, 0);
    chk("t4_full_tag", disp_tag, 0);
    disp(4'd0, 32'd999, 1'b1, 4'd0, 32'd0, 1'b1, 4'd0);
    tick();
    idle();
    chk("t4_still_full", disp_ready, 0);
    chk("t4_hold_tag", iss_rd_tag, 1);
    chk("t4_hold_v1", iss_V1, 100);
    alu_done = 1'b1;
    tick();
    alu_done = 1'b0;
    chk("t4_reuse_tag", disp_tag, 1);
    chk("t4_reuse_rdy", disp_ready, 1);
    chk("t4_next_tag", iss_rd_tag, 2);
    chk("t4_next_v1", iss_V1, 101);
    alu_done = 1'b1;
    tick();
    chk("t4_drain_3", iss_rd_tag, 3);
    tick();
    chk("t4_drain_4", iss_rd_tag, 4);
    chk("t4_drain_4v1", iss_V1, 103);
    tick();
    alu_done = 1'b0;
    chk("t4_empty", iss_valid, 0);

    // 5: out-of-order issue around a waiting entry, back-to-back
    disp(4'd0, 32'd11, 1'b1, 4'd0, 32'd0, 1'b1, 4'd0);
    tick();
    disp(4'd0, 32'd0, 1'b0, 4'd9, 32'd0, 1'b1, 4'd0);
    tick();
    disp(4'd0, 32'd33, 1'b1, 4'd0, 32'd0, 1'b1, 4'd0);
    tick();
    idle();
    chk("t5_first", iss_rd_tag, 1);
    alu_done = 1'b1;
    CDB_tag  = 4'd9;
    CDB_val  = 32'd22;
    tick();
    CDB_tag  = 4'd0;
    CDB_val  = 32'd0;
    chk("t5_second", iss_rd_tag, 3);
    chk("t5_second_v1", iss_V1, 33);
    tick();
    chk("t5_third", iss_rd_tag, 2);
    chk("t5_third_v1", iss_V1, 22);
    tick();
    alu_done = 1'b0;
    chk("t5_empty", iss_valid, 0);

    // 6: flush beats a concurrent dispatch, then async reset mid-issue
    for (int i = 0; i < 3; i++) begin
      disp(4'd0, 32'd50 + 32'(i), 1'b1, 4'd0, 32'd0, 1'b1, 4'd0);
      tick();
    end
    chk("t6_pre_valid", iss_valid, 1);
    chk("t6_pre_tag", disp_tag, 4);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    idle();
    chk("t6_fl_valid", iss_valid, 0);
    chk("t6_fl_rdy", disp_ready, 1);
    chk("t6_fl_tag", disp_tag, 1);
    tick();
    chk("t6_fl_quiet", iss_valid, 0);
    disp(4'd3, 32'd77, 1'b1, 4'd0, 32'd1, 1'b1, 4'd0);
    tick();
    idle();
    tick();
    chk("t6_rs_pre", iss_valid, 1);
    #2;
    RST_N = 1'b0;
    #1;
    chk("t6_rs_async", iss_valid, 0);
    chk("t6_rs_tag", iss_rd_tag, 0);
    tick();
    RST_N = 1'b1;
    tick();
    chk("t6_rs_disp", disp_tag, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
